// File: rtl/vc_plane_scheduler.sv
// Rotating VC-plane selector: one registered plane index with optional idle-skip,
// fanned out to four pipeline stages either directly or through a 3-deep delay line.
module vc_plane_scheduler #(
  parameter  int VC        = 4,
  parameter  int SKIP_IDLE = 1,
  parameter  int STAGGER   = 1,
  localparam int SEL_W     = ($clog2(VC) > 1) ? $clog2(VC) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [VC-1:0]    vcActive,
  input  logic             hold,
  output logic [SEL_W-1:0] VCPlaneSelectorCFSM,
  output logic [SEL_W-1:0] VCPlaneSelectorHFB,
  output logic [SEL_W-1:0] VCPlaneSelectorVCG,
  output logic [SEL_W-1:0] VCPlaneSelectorSwitchControl,
  output logic [VC-1:0]    planeOneHot,
  output logic             planeValid
);

  logic [SEL_W-1:0] r_cur;
  logic [SEL_W-1:0] w_adv;
  logic [SEL_W-1:0] w_next;
  logic [SEL_W:0]   w_sum;
  logic             w_found;

  always_comb begin
    w_adv   = (r_cur == SEL_W'(VC - 1)) ? '0 : r_cur + 1'b1;
    w_next  = w_adv;
    w_sum   = '0;
    w_found = 1'b0;
    if (SKIP_IDLE != 0) begin
      // Offsets 1..VC scanned in order; offset VC lands on cur itself, so it is checked last.
      for (int unsigned k = 1; k <= VC; k++) begin
        w_sum = {1'b0, r_cur} + (SEL_W + 1)'(k);
        if (w_sum >= (SEL_W + 1)'(VC))
          w_sum = w_sum - (SEL_W + 1)'(VC);
        if (!w_found && vcActive[w_sum[SEL_W-1:0]]) begin
          w_next  = w_sum[SEL_W-1:0];
          w_found = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_cur <= '0;
    else if (!hold)
      r_cur <= w_next;
  end

  assign VCPlaneSelectorCFSM = r_cur;
  assign planeOneHot         = VC'(1) << r_cur;
  assign planeValid          = vcActive[r_cur];

  if (STAGGER != 0) begin : g_stagger
    logic [SEL_W-1:0] r_dly [3];

    // Shifts every cycle, even while rotation is held.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_dly[0] <= '0;
        r_dly[1] <= '0;
        r_dly[2] <= '0;
      end else begin
        r_dly[0] <= r_cur;
        r_dly[1] <= r_dly[0];
        r_dly[2] <= r_dly[1];
      end
    end

    assign VCPlaneSelectorHFB           = r_dly[0];
    assign VCPlaneSelectorVCG           = r_dly[1];
    assign VCPlaneSelectorSwitchControl = r_dly[2];
  end else begin : g_flat
    assign VCPlaneSelectorHFB           = r_cur;
    assign VCPlaneSelectorVCG           = r_cur;
    assign VCPlaneSelectorSwitchControl = r_cur;
  end

endmodule

// File: tb/tb_vc_plane_scheduler.sv
// Scoreboard bench for vc_plane_scheduler: three configurations share stimulus,
// a plane-list reference model queues expected outputs, a monitor compares them.
module tb_vc_plane_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       hold = 1'b0;
  logic [3:0] act = 4'h0;

  logic [1:0] a_c, a_h, a_v, a_s;  logic [3:0] a_oh;  logic a_pv;
  logic [1:0] b_c, b_h, b_v, b_s;  logic [3:0] b_oh;  logic b_pv;
  logic [1:0] c_c, c_h, c_v, c_s;  logic [2:0] c_oh;  logic c_pv;

  vc_plane_scheduler #(.VC(4), .SKIP_IDLE(1), .STAGGER(1)) u_a (
    .clk(clk), .rst(rst), .vcActive(act), .hold(hold),
    .VCPlaneSelectorCFSM(a_c), .VCPlaneSelectorHFB(a_h), .VCPlaneSelectorVCG(a_v),
    .VCPlaneSelectorSwitchControl(a_s), .planeOneHot(a_oh), .planeValid(a_pv));

  vc_plane_scheduler #(.VC(4), .SKIP_IDLE(0), .STAGGER(1)) u_b (
    .clk(clk), .rst(rst), .vcActive(act), .hold(hold),
    .VCPlaneSelectorCFSM(b_c), .VCPlaneSelectorHFB(b_h), .VCPlaneSelectorVCG(b_v),
    .VCPlaneSelectorSwitchControl(b_s), .planeOneHot(b_oh), .planeValid(b_pv));

  vc_plane_scheduler #(.VC(3), .SKIP_IDLE(0), .STAGGER(0)) u_c (
    .clk(clk), .rst(rst), .vcActive(act[2:0]), .hold(hold),
    .VCPlaneSelectorCFSM(c_c), .VCPlaneSelectorHFB(c_h), .VCPlaneSelectorVCG(c_v),
    .VCPlaneSelectorSwitchControl(c_s), .planeOneHot(c_oh), .planeValid(c_pv));

  typedef struct { int v[18]; } exp_t;
  exp_t q[$];

  int vectors = 0;
  int miscompares = 0;

  int cfg_vc   [3] = '{4, 4, 3};
  int cfg_skip [3] = '{1, 0, 0};
  int cfg_stag [3] = '{1, 1, 0};
  int mh [3][4];  // mh[d][0] = current plane, mh[d][k] = plane k cycles ago

  string fname [6] = '{"cfsm", "hfb", "vcg", "switchctl", "onehot", "valid"};

  // Smallest active plane above cur, else smallest active overall (may be cur), else cur+1.
  function automatic int next_cur(int cur, int vc, int skip, logic [3:0] a);
    int best = -1;
    if (skip != 0) begin
      for (int j = 0; j < vc; j++)
        if (a[j] && j > cur && best < 0) best = j;
      for (int j = 0; j < vc; j++)
        if (a[j] && best < 0) best = j;
    end
    if (best < 0) best = (cur + 1) % vc;
    return best;
  endfunction

  task automatic step(input logic r, input logic h, input logic [3:0] a);
    exp_t e;
    logic [3:0] m;
    int nc;
    @(negedge clk);
    rst  = r;
    hold = h;
    act  = a;
    for (int d = 0; d < 3; d++) begin
      m = (cfg_vc[d] == 3) ? {1'b0, a[2:0]} : a;
      if (r) begin
        for (int k = 0; k < 4; k++) mh[d][k] = 0;
      end else begin
        nc = h ? mh[d][0] : next_cur(mh[d][0], cfg_vc[d], cfg_skip[d], m);
        for (int k = 3; k > 0; k--) mh[d][k] = mh[d][k-1];
        mh[d][0] = nc;
      end
      e.v[d*6+0] = mh[d][0];
      e.v[d*6+1] = (cfg_stag[d] != 0) ? mh[d][1] : mh[d][0];
      e.v[d*6+2] = (cfg_stag[d] != 0) ? mh[d][2] : mh[d][0];
      e.v[d*6+3] = (cfg_stag[d] != 0) ? mh[d][3] : mh[d][0];
      e.v[d*6+4] = 1 << mh[d][0];
      e.v[d*6+5] = int'(m[mh[d][0]]);
    end
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    int got [18];
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        got = '{int'(a_c), int'(a_h), int'(a_v), int'(a_s), int'(a_oh), int'(a_pv),
                int'(b_c), int'(b_h), int'(b_v), int'(b_s), int'(b_oh), int'(b_pv),
                int'(c_c), int'(c_h), int'(c_v), int'(c_s), int'(c_oh), int'(c_pv)};
        for (int i = 0; i < 18; i++) begin
          vectors++;
          if (got[i] !== e.v[i]) begin
            miscompares++;
            $display("FAIL %s dut%0d at %0t: got %0d expected %0d",
                     fname[i % 6], i / 6, $time, got[i], e.v[i]);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic [3:0] ra;
    // Fixed rotation / wrap / stagger taps from reset.
    step(1'b1, 1'b0, 4'hF);
    repeat (10) step(1'b0, 1'b0, 4'hF);
    // Skip-idle over 1010.
    step(1'b1, 1'b0, 4'b1010);
    repeat (4) step(1'b0, 1'b0, 4'b1010);
    // Lone active plane parks, then hold freezes rotation, then release.
    repeat (3) step(1'b0, 1'b0, 4'b0100);
    repeat (3) step(1'b0, 1'b1, 4'hF);
    step(1'b0, 1'b0, 4'hF);
    // Reset mid-rotation (also with hold asserted), then all-idle advance.
    step(1'b1, 1'b1, 4'hF);
    step(1'b0, 1'b0, 4'hF);
    step(1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b0, 4'h0);
    repeat (300) begin
      ra = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom);
      step($urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0, ra);
    end
    @(posedge clk);
    #3;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vc_plane_scheduler.md
VC_PLANE_SCHEDULER -- requirements
Module: vc_plane_scheduler

Interface
REQ-001 The block SHALL have parameter VC, default 4: number of VC planes; legal values are 2 or more.
REQ-002 The block SHALL have parameter SKIP_IDLE, default 1: 0 selects fixed rotation, 1 selects work-conserving rotation that skips idle planes.
REQ-003 The block SHALL have parameter STAGGER, default 1: 0 drives all four selectors from the same cycle, 1 delays each downstream selector by one extra cycle.
REQ-004 The block SHALL define derived width SEL_W = max(1, clog2(VC)).
REQ-005 The block SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 vcActive  input  VC  bit i high means plane i holds buffered or in-flight traffic.
REQ-009 hold  input  1  freezes plane rotation for the current cycle.
REQ-010 VCPlaneSelectorCFSM  output  SEL_W  active plane index, stage 0.
REQ-011 VCPlaneSelectorHFB  output  SEL_W  plane index, stage 1.
REQ-012 VCPlaneSelectorVCG  output  SEL_W  plane index, stage 2.
REQ-013 VCPlaneSelectorSwitchControl  output  SEL_W  plane index, stage 3.
REQ-014 planeOneHot  output  VC  one-hot decode of VCPlaneSelectorCFSM.
REQ-015 planeValid  output  1  high when vcActive[VCPlaneSelectorCFSM] is high.

Function
REQ-016 The block SHALL hold the current plane in a registered index cur; VCPlaneSelectorCFSM SHALL equal cur.
REQ-017 When hold=1, cur SHALL be unchanged on the next edge, regardless of vcActive.
REQ-018 When hold=0 and SKIP_IDLE=0, cur SHALL advance to cur+1, and from VC-1 SHALL wrap to 0, including for non-power-of-two VC.
REQ-019 When hold=0 and SKIP_IDLE=1, next cur SHALL be the first index j with vcActive[j]=1, searched cyclically in the order cur+1, cur+2, ..., cur+VC (mod VC).
REQ-020 In the SKIP_IDLE=1 search, cur itself is checked last, so a lone active plane SHALL keep cur unchanged.
REQ-021 When hold=0, SKIP_IDLE=1 and vcActive is all zero, cur SHALL advance as in REQ-018.
REQ-022 The next-cur decision SHALL use vcActive sampled in the same cycle: latency from a vcActive change to a cur change is 1 cycle.
REQ-023 cur SHALL never take a value of VC or above.
REQ-024 When STAGGER=1, HFB, VCG and SwitchControl SHALL equal VCPlaneSelectorCFSM delayed by 1, 2 and 3 cycles respectively, using a register delay line.
REQ-025 The STAGGER=1 delay line SHALL shift every cycle, independent of hold.
REQ-026 When STAGGER=0, all four selectors SHALL equal cur combinationally.
REQ-027 planeOneHot and planeValid SHALL be combinational from cur and vcActive: planeOneHot has exactly one bit set at all times, and planeValid has zero added latency.

Reset
REQ-028 When rst=1 at a rising edge, cur and all delay-line registers SHALL become 0, so all selectors read 0, planeOneHot reads 1, and planeValid reads vcActive[0].
REQ-029 rst SHALL take priority over hold.
REQ-030 Asserting rst in the middle of a rotation SHALL discard the in-progress position; the first post-reset advance SHALL start from 0.
REQ-031 There SHALL be no initial-value dependence: outputs are defined only after the first reset edge.

Verification
REQ-032 Fixed rotation, VC=4, SKIP_IDLE=0, hold=0, reset, 10 cycles -> CFSM reads 0,1,2,3,0,1,2,3,0,1.
REQ-033 Non-power-of-two wrap, VC=3, SKIP_IDLE=0 -> CFSM reads 0,1,2,0,1,2 and never 3.
REQ-034 Skip-idle, VC=4, vcActive=4'b1010 from reset -> CFSM reads 0,1,3,1,3, with planeValid 0,1,1,1,1.
REQ-035 Lone active plane and hold -> vcActive=4'b0100 parks CFSM at 2; then hold=1 for 3 cycles with vcActive=4'b1111 keeps CFSM at 2; releasing hold gives 3 next.
REQ-036 STAGGER=1, fixed rotation -> at cycle 5 after reset CFSM=1, HFB=0, VCG=3, SwitchControl=2.
REQ-037 Reset mid-operation, CFSM=2, rst pulsed 1 cycle -> all selectors read 0 on the next cycle, and the cycle after that CFSM=1 (vcActive=1111).
